seq_normalizer_16bit: RTL and testbench

Iterative 16-bit normalizer: the inverse of a barrel shift. Given a word, it finds the shift amount that brings the first set bit to the MSB (left mode) or to the LSB (right mode). It returns both the normalized word and the amount. It shifts one bit per clock under a start/done handshake and serves as the leading-/trailing-zero front end ahead of the 16-bit shifters in the datapath.

---
 rtl/shift_pkg.sv | 16 +
 rtl/seq_normalizer_16bit.sv | 121 ++++++++++++
 tb/tb_seq_normalizer_16bit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the shifter/normalizer datapath: FSM state encodings,
// direction codes (also used as the 'choice' select of the combinational
// shifters) and default widths.
package shift_pkg;

  localparam int W  = 16;
  localparam int AW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seq_normalizer_16bit.sv
// Iterative normalizer: shifts the captured operand one bit per clock until
// its first set bit reaches bit 15 (left) or bit 0 (right), then reports the
// normalized word and the number of shifts applied. A zero operand finishes
// immediately with the zero flag set.
module seq_normalizer_16bit #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic          dir,
  output logic [W-1:0]  y,
  output logic [AW-1:0] amt,
  output logic          zero,
  output logic          busy,
  output logic          done
);

  import shift_pkg::*;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [W-1:0]  r;
  logic [W-1:0]  r_nx;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nx;
  logic          d;
  logic          d_nx;
  logic [W-1:0]  y_nx;
  logic [AW-1:0] amt_nx;
  logic          zero_nx;
  logic          hit;

  // Bit that must be set for the word to count as normalized in direction d.
  always_comb begin
    if (d == DIR_LEFT) begin
      hit = r[W-1];
    end else begin
      hit = r[0];
    end
  end

  // Next-state and datapath update; outputs only change on SHIFT->DONE.
  always_comb begin
    state_nx = state;
    r_nx     = r;
    cnt_nx   = cnt;
    d_nx     = d;
    y_nx     = y;
    amt_nx   = amt;
    zero_nx  = zero;
    case (state)
      S_IDLE: begin
        if (start) begin
          r_nx     = a;
          d_nx     = dir;
          cnt_nx   = {AW{1'b0}};
          state_nx = S_SHIFT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r == {W{1'b0}}) begin
          zero_nx  = 1'b1;
          y_nx     = {W{1'b0}};
          amt_nx   = {AW{1'b0}};
          state_nx = S_DONE;
        end else if (hit) begin
          zero_nx  = 1'b0;
          y_nx     = r;
          amt_nx   = cnt;
          state_nx = S_DONE;
        end else begin
          // A nonzero word reaches its target bit within W-1 shifts, so cnt cannot wrap.
          if (d == DIR_LEFT) begin
            r_nx = {r[W-2:0], 1'b0};
          end else begin
            r_nx = {1'b0, r[W-1:1]};
          end
          cnt_nx   = cnt + {{(AW-1){1'b0}}, 1'b1};
          state_nx = S_SHIFT;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      r     <= {W{1'b0}};
      cnt   <= {AW{1'b0}};
      d     <= DIR_LEFT;
      y     <= {W{1'b0}};
      amt   <= {AW{1'b0}};
      zero  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
      cnt   <= cnt_nx;
      d     <= d_nx;
      y     <= y_nx;
      amt   <= amt_nx;
      zero  <= zero_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_seq_normalizer_16bit.sv
// Self-checking bench for seq_normalizer_16bit: directed table, hand-written
// corner sequences (ignored start, mid-operation reset) and a random sweep,
// all checked through an expected-result queue.
module tb_seq_normalizer_16bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic        dir;
  logic [15:0] y;
  logic [3:0]  amt;
  logic        zero;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] a;
    logic        dir;
    logic [15:0] y;
    logic [3:0]  amt;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[11];

  seq_normalizer_16bit #(.W(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .dir   (dir),
    .y     (y),
    .amt   (amt),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Independent reference: locate the first set bit by index.
  function automatic vec_t model(input logic [15:0] op, input logic dr);
    vec_t v;
    int p;
    v.a = op; v.dir = dr; v.zero = (op == 16'h0000);
    v.y = 16'h0000; v.amt = 4'd0;
    p = -1;
    if (!v.zero) begin
      if (dr == 1'b0) begin
        for (int i = 0; i < 16; i++) if (op[i]) p = i;
        v.amt = 4'(15 - p);
        v.y = op << (15 - p);
      end else begin
        for (int i = 15; i >= 0; i--) if (op[i]) p = i;
        v.amt = 4'(p);
        v.y = op >> p;
      end
    end
    v.lat = 32'(v.amt) + 2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operation; optionally re-pulse start (0xFFFF) at cycle 'poke'.
  task automatic run_op(input logic [15:0] op, input logic dr, input vec_t e, input int poke);
    int   lat;
    int   busy_cnt;
    bit   seen;
    vec_t g;
    sb.push_back(e);
    a = op; dir = dr; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom);
    dir = 1'($urandom);
    lat = 1; busy_cnt = 0; seen = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    while (!seen && lat < 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (lat == poke) begin
          start = 1'b1;
          a = 16'hFFFF;
        end
        tick();
        start = 1'b0;
        lat++;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=none expected=done a=%0h", op);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty actual=done expected=no_done");
    end else begin
      g = sb.pop_front();
      chk("y", 32'(y), 32'(g.y));
      chk("amt", 32'(amt), 32'(g.amt));
      chk("zero", 32'(zero), 32'(g.zero));
      chk("latency", 32'(lat), 32'(g.lat));
      chk("busy_len", 32'(busy_cnt), 32'(g.lat));
      if (!g.zero) begin
        if (g.dir == 1'b0) chk("y_msb", 32'(y[15]), 32'd1);
        else               chk("y_lsb", 32'(y[0]), 32'd1);
      end
    end
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t e;
    logic [15:0] op;
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; a = 16'h0000; dir = 1'b0;

    tbl[0]  = '{16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0, 17};
    tbl[1]  = '{16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0, 2};
    tbl[2]  = '{16'h00F0, 1'b1, 16'h000F, 4'd4,  1'b0, 6};
    tbl[3]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1, 2};
    tbl[4]  = '{16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1, 2};
    tbl[5]  = '{16'h0100, 1'b0, 16'h8000, 4'd7,  1'b0, 9};
    tbl[6]  = '{16'h8000, 1'b1, 16'h0001, 4'd15, 1'b0, 17};
    tbl[7]  = '{16'h0001, 1'b1, 16'h0001, 4'd0,  1'b0, 2};
    tbl[8]  = '{16'hFFFF, 1'b0, 16'hFFFF, 4'd0,  1'b0, 2};
    tbl[9]  = '{16'h0A00, 1'b1, 16'h0005, 4'd9,  1'b0, 11};
    tbl[10] = '{16'h0350, 1'b0, 16'hD400, 4'd6,  1'b0, 8};

    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_amt", 32'(amt), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].a, tbl[i].dir, tbl[i], 0);
    end

    // Start pulsed during SHIFT must be ignored and leave a single done.
    e = '{16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0, 13};
    run_op(16'h0010, 1'b0, e, 3);
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        checks++; failures++;
        $display("FAIL extra_done actual=1 expected=0 cycle=%0d", i);
      end
      tick();
    end
    chk("extra_busy", 32'(busy), 32'd0);

    // Reset three cycles into a long operation: no done, outputs cleared.
    a = 16'h0001; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("pre_rst_done", 32'(done), 32'd0);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_amt", 32'(amt), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    run_op(16'h0040, 1'b1, model(16'h0040, 1'b1), 0);

    // Random sweep, both directions, occasionally biased toward long shifts.
    for (int i = 0; i < 10000; i++) begin
      op = 16'($urandom);
      if ($urandom_range(0, 7) == 0) op = op >> $urandom_range(0, 15);
      if ($urandom_range(0, 63) == 0) op = 16'h0000;
      e = model(op, 1'($urandom));
      run_op(op, e.dir, e, 0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
